// File: rtl/calc_cmd_sequencer_if.sv
// Host command channel of the calculator command sequencer: valid/ready
// handshake carrying one (operand, op) command per transfer.
interface calc_cmd_sequencer_if;
    logic       CmdValid;
    logic       CmdReady;
    logic [7:0] CmdNum;
    logic [1:0] CmdOp;

    modport master (output CmdValid, output CmdNum, output CmdOp, input CmdReady);
    modport slave  (input CmdValid, input CmdNum, input CmdOp, output CmdReady);
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Buffers host (operand, op) commands and replays each to the calculator as setup,
// one-cycle Enter, then release. Optional shadow result check: `define CALC_SHADOW_EN.
module calc_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int RELEASE_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   Reset_n,
    calc_cmd_sequencer_if.slave    cmd,
    input  logic                   Flush,
    output logic                   Enter,
    output logic [7:0]             NumIn,
    output logic [1:0]             OpIn,
    output logic                   CalcClear,
    output logic                   Busy,
    output logic                   Done,
    output logic [$clog2(DEPTH):0] Count
`ifdef CALC_SHADOW_EN
    ,
    input  logic [7:0]             NumOut,
    output logic                   Mismatch
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
    localparam logic [RW-1:0] REL_LAST_C = RW'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PRESS   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t        state_r, next_state_s;
    logic [RW-1:0] rel_cnt_r, rel_cnt_nxt_s;
    logic          rel_last_s;

    logic [9:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s, pop_s;

    logic          enter_r, enter_nxt_s;
    logic          done_r, done_nxt_s;
    logic          calc_clear_r, flush_d_r;
    logic [7:0]    num_in_r;
    logic [1:0]    op_in_r;

    assign cmd.CmdReady = (count_r < FULL_C) && !Flush;
    assign push_s       = cmd.CmdValid && cmd.CmdReady;
    assign pop_s        = (state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && !Flush;
    assign rel_last_s   = (rel_cnt_r == REL_LAST_C);

    // Command storage, pointers and occupancy; Flush empties the queue in one cycle.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (Flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {cmd.CmdOp, cmd.CmdNum};
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register and release-phase counter.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            rel_cnt_r <= {RW{1'b0}};
        end else begin
            state_r   <= next_state_s;
            rel_cnt_r <= rel_cnt_nxt_s;
        end
    end

    // Next-state logic; Flush forces IDLE ahead of everything else.
    always_comb begin
        next_state_s  = state_r;
        rel_cnt_nxt_s = rel_cnt_r;
        if (Flush) begin
            next_state_s  = ST_IDLE;
            rel_cnt_nxt_s = {RW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r != {CW{1'b0}}) begin
                        next_state_s = ST_SETUP;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_SETUP: next_state_s = ST_PRESS;
                ST_PRESS: begin
                    next_state_s  = ST_RELEASE;
                    rel_cnt_nxt_s = {RW{1'b0}};
                end
                ST_RELEASE: begin
                    if (rel_last_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s  = ST_RELEASE;
                        rel_cnt_nxt_s = rel_cnt_r + RW'(1'b1);
                    end
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so Enter and Done leave flops directly.
    always_comb begin
        enter_nxt_s = 1'b0;
        done_nxt_s  = 1'b0;
        if (next_state_s == ST_PRESS) begin
            enter_nxt_s = 1'b1;
        end else if ((next_state_s == ST_RELEASE) && (rel_cnt_nxt_s == REL_LAST_C)) begin
            done_nxt_s = 1'b1;
        end else begin
            enter_nxt_s = 1'b0;
            done_nxt_s  = 1'b0;
        end
    end

    // Registered calculator-side outputs; CalcClear fires once per Flush burst.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            enter_r      <= 1'b0;
            done_r       <= 1'b0;
            calc_clear_r <= 1'b0;
            flush_d_r    <= 1'b0;
            num_in_r     <= 8'd0;
            op_in_r      <= 2'd0;
        end else begin
            enter_r      <= enter_nxt_s;
            done_r       <= done_nxt_s;
            calc_clear_r <= Flush && !flush_d_r;
            flush_d_r    <= Flush;
            if (pop_s) begin
                {op_in_r, num_in_r} <= mem_r[rd_ptr_r];
            end
        end
    end

    assign Enter     = enter_r;
    assign Done      = done_r;
    assign CalcClear = calc_clear_r;
    assign NumIn     = num_in_r;
    assign OpIn      = op_in_r;
    assign Count     = count_r;
    assign Busy      = (state_r != ST_IDLE) || (count_r != {CW{1'b0}});

`ifdef CALC_SHADOW_EN
    logic [7:0] shadow_r;
    logic       mismatch_r;

    function automatic logic [7:0] calc_step(input logic [7:0] acc, input logic [7:0] num,
                                             input logic [1:0] op);
        case (op)
            2'd0:    calc_step = acc + num;
            2'd1:    calc_step = acc - num;
            2'd2:    calc_step = acc | num;
            default: calc_step = (acc == num) ? 8'd1 : 8'd0;
        endcase
    endfunction

    // Shadow accumulator follows each press; result compared at end of release.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_r   <= 8'd0;
            mismatch_r <= 1'b0;
        end else if (Flush) begin
            shadow_r   <= 8'd0;
            mismatch_r <= 1'b0;
        end else begin
            if (state_r == ST_PRESS) begin
                shadow_r <= calc_step(shadow_r, num_in_r, op_in_r);
            end
            if ((state_r == ST_RELEASE) && rel_last_s && (NumOut != shadow_r)) begin
                mismatch_r <= 1'b1;
            end
        end
    end

    assign Mismatch = mismatch_r;
`endif
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer: queue/age reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_calc_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int REL   = 1;

    logic       clock   = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Flush   = 1'b0;
    logic       Enter, CalcClear, Busy, Done;
    logic [7:0] NumIn;
    logic [1:0] OpIn;
    logic [2:0] Count;
    logic [7:0] calc_acc = 8'd0;
    logic [7:0] calc_out;
    logic       corrupt  = 1'b0;
`ifdef CALC_SHADOW_EN
    logic       Mismatch;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    calc_cmd_sequencer_if cmd_if();

    calc_cmd_sequencer #(.DEPTH(DEPTH), .RELEASE_CYCLES(REL)) dut (
        .clock    (clock),
        .Reset_n  (Reset_n),
        .cmd      (cmd_if),
        .Flush    (Flush),
        .Enter    (Enter),
        .NumIn    (NumIn),
        .OpIn     (OpIn),
        .CalcClear(CalcClear),
        .Busy     (Busy),
        .Done     (Done),
        .Count    (Count)
`ifdef CALC_SHADOW_EN
        ,
        .NumOut   (calc_out),
        .Mismatch (Mismatch)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] calc_fn(input logic [7:0] s, input logic [7:0] n,
                                           input logic [1:0] op);
        case (op)
            2'd0:    calc_fn = s + n;
            2'd1:    calc_fn = s - n;
            2'd2:    calc_fn = s | n;
            default: calc_fn = (s == n) ? 8'd1 : 8'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in calculator: acts on each Enter, wiped by CalcClear.
    always @(posedge clock or negedge Reset_n) begin
        if (!Reset_n)       calc_acc <= 8'd0;
        else if (CalcClear) calc_acc <= 8'd0;
        else if (Enter)     calc_acc <= calc_fn(calc_acc, NumIn, OpIn);
    end
    assign calc_out = calc_acc ^ {8{corrupt}};

    // Reference model: a queue of commands plus "edges since pop" for the active one.
    logic [9:0] mq[$];
    bit         m_active = 1'b0;
    int         m_age    = 0;
    int         m_sz     = 0;
    logic [7:0] m_num    = 8'd0;
    logic [1:0] m_op     = 2'd0;
    bit         m_flush_d = 1'b0;
    bit         m_clear  = 1'b0;
    logic [7:0] m_shadow = 8'd0;
    bit         m_mism   = 1'b0;

    always @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mq.delete();
            m_active = 1'b0; m_age = 0; m_num = 8'd0; m_op = 2'd0;
            m_flush_d = 1'b0; m_clear = 1'b0; m_shadow = 8'd0; m_mism = 1'b0;
        end else begin
            m_sz    = mq.size();
            m_clear = Flush && !m_flush_d;
            if (Flush) begin
                mq.delete();
                m_active = 1'b0; m_shadow = 8'd0; m_mism = 1'b0;
            end else begin
                if (m_active) begin
                    if (m_age == 1) m_shadow = calc_fn(m_shadow, m_num, m_op);
                    if (m_age == REL + 1 && calc_out != m_shadow) m_mism = 1'b1;
                    m_age++;
                    if (m_age == REL + 2) m_active = 1'b0;
                end else if (m_sz > 0) begin
                    {m_op, m_num} = mq.pop_front();
                    m_active = 1'b1;
                    m_age    = 0;
                end
                if (cmd_if.CmdValid && m_sz < DEPTH) mq.push_back({cmd_if.CmdOp, cmd_if.CmdNum});
            end
            m_flush_d = Flush;
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clock) begin
        check("Count",     32'(Count),     32'(mq.size()));
        check("Enter",     32'(Enter),     32'(m_active && m_age == 1));
        check("Done",      32'(Done),      32'(m_active && m_age == REL + 1));
        check("NumIn",     32'(NumIn),     32'(m_num));
        check("OpIn",      32'(OpIn),      32'(m_op));
        check("CalcClear", 32'(CalcClear), 32'(m_clear));
        check("Busy",      32'(Busy),      32'(m_active || mq.size() > 0));
        check("CmdReady",  32'(cmd_if.CmdReady), 32'((mq.size() < DEPTH) && !Flush));
`ifdef CALC_SHADOW_EN
        check("Mismatch",  32'(Mismatch),  32'(m_mism));
`endif
    end

    logic [9:0] seen[$];
    int         done_cnt = 0;
    int         clr_cnt  = 0;

    always @(negedge clock) begin
        if (Enter)     seen.push_back({OpIn, NumIn});
        if (Done)      done_cnt++;
        if (CalcClear) clr_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic put(input logic [1:0] op, input logic [7:0] num);
        cmd_if.CmdValid = 1'b1;
        cmd_if.CmdOp    = op;
        cmd_if.CmdNum   = num;
        step();
    endtask

    task automatic drain(input int n);
        cmd_if.CmdValid = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_enter(input logic [7:0] num);
        int k = 0;
        while (!(Enter && NumIn == num) && k < 50) begin
            step();
            k++;
        end
        check("wait_enter", 32'(k < 50), 32'd1);
    endtask

    task automatic check_seen(input string name, input logic [9:0] exp[$]);
        check({name, "_len"}, 32'(seen.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < seen.size()) check(name, 32'(seen[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [9:0] exp_q[$];
        cmd_if.CmdValid = 1'b0;
        cmd_if.CmdNum   = 8'd0;
        cmd_if.CmdOp    = 2'd0;
        repeat (2) @(posedge clock);
        #2 Reset_n = 1'b1;
        step();
        check("rst_count", 32'(Count), 32'd0);
        check("rst_busy",  32'(Busy),  32'd0);
        check("rst_ready", 32'(cmd_if.CmdReady), 32'd1);

        // Single add 5: press two edges after the push, Done on the following cycle.
        put(2'd0, 8'd5);
        cmd_if.CmdValid = 1'b0;
        check("t1_count", 32'(Count), 32'd1);
        step();
        check("t1_setup_enter", 32'(Enter), 32'd0);
        step();
        check("t1_enter", 32'(Enter), 32'd1);
        check("t1_numin", 32'(NumIn), 32'd5);
        check("t1_opin",  32'(OpIn),  32'd0);
        step();
        check("t1_enter_low", 32'(Enter), 32'd0);
        check("t1_done",      32'(Done),  32'd1);
        step();
        check("t1_done_low",  32'(Done),  32'd0);
        check("t1_busy",      32'(Busy),  32'd0);
        drain(4);

        // Fill to full behind an active command; a further valid is refused.
        seen.delete();
        put(2'd0, 8'd1);
        put(2'd0, 8'd10);
        put(2'd1, 8'd3);
        put(2'd2, 8'h80);
        put(2'd3, 8'h87);
        check("t2_full_count", 32'(Count), 32'd4);
        check("t2_full_ready", 32'(cmd_if.CmdReady), 32'd0);
        put(2'd0, 8'h55);
        cmd_if.CmdValid = 1'b0;
        check("t2_not_taken", 32'(Count), 32'd3);
        drain(25);
        exp_q = '{{2'd0, 8'd1}, {2'd0, 8'd10}, {2'd1, 8'd3}, {2'd2, 8'h80}, {2'd3, 8'h87}};
        check_seen("t2_order", exp_q);

        // Push coinciding with pop at Count=2.
        seen.delete();
        put(2'd0, 8'h11);
        put(2'd1, 8'h22);
        put(2'd2, 8'h33);
        drain(2);
        put(2'd3, 8'h44);
        cmd_if.CmdValid = 1'b0;
        check("t3_count", 32'(Count), 32'd2);
        drain(20);
        exp_q = '{{2'd0, 8'h11}, {2'd1, 8'h22}, {2'd2, 8'h33}, {2'd3, 8'h44}};
        check_seen("t3_order", exp_q);

        // Flush during the press of the second of three queued commands.
        put(2'd0, 8'h21);
        put(2'd0, 8'h42);
        put(2'd0, 8'h63);
        cmd_if.CmdValid = 1'b0;
        wait_enter(8'h42);
        clr_cnt = 0;
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("t4_enter",  32'(Enter),     32'd0);
        check("t4_count",  32'(Count),     32'd0);
        check("t4_clear",  32'(CalcClear), 32'd1);
        check("t4_done",   32'(Done),      32'd0);
        seen.delete();
        done_cnt = 0;
        drain(10);
        check("t4_no_enter", 32'(seen.size()), 32'd0);
        check("t4_no_done",  32'(done_cnt),    32'd0);
        check("t4_one_clear", 32'(clr_cnt),    32'd1);

        // Held Flush yields a single CalcClear pulse.
        clr_cnt = 0;
        Flush = 1'b1;
        repeat (3) step();
        Flush = 1'b0;
        drain(3);
        check("t4_burst_clear", 32'(clr_cnt), 32'd1);

        // Async reset in the middle of a press.
        put(2'd0, 8'h77);
        cmd_if.CmdValid = 1'b0;
        wait_enter(8'h77);
        #1 Reset_n = 1'b0;
        #1;
        check("t5_async_enter", 32'(Enter), 32'd0);
        @(posedge clock);
        #2 Reset_n = 1'b1;
        step();
        check("t5_count", 32'(Count), 32'd0);
        check("t5_busy",  32'(Busy),  32'd0);

`ifdef CALC_SHADOW_EN
        // Shadow: 200 + 100 wraps to 44; a wrong result after a press sets sticky Mismatch.
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        step();
        put(2'd0, 8'd200);
        put(2'd0, 8'd100);
        drain(12);
        check("t6_acc",      32'(calc_acc), 32'd44);
        check("t6_mismatch", 32'(Mismatch), 32'd0);
        put(2'd0, 8'd1);
        cmd_if.CmdValid = 1'b0;
        wait_enter(8'd1);
        step();
        corrupt = 1'b1;
        repeat (3) step();
        check("t6_mismatch_set", 32'(Mismatch), 32'd1);
        corrupt = 1'b0;
        drain(3);
        check("t6_mismatch_sticky", 32'(Mismatch), 32'd1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("t6_mismatch_clr", 32'(Mismatch), 32'd0);
        drain(2);
`endif

        // Randomized traffic with occasional flushes and calculator faults.
        for (int i = 0; i < 1500; i++) begin
            cmd_if.CmdValid = ($urandom_range(0, 9) < 6);
            cmd_if.CmdNum   = 8'($urandom);
            cmd_if.CmdOp    = 2'($urandom);
            Flush           = ($urandom_range(0, 39) == 0);
            corrupt         = ($urandom_range(0, 63) == 0);
            step();
        end
        Flush   = 1'b0;
        corrupt = 1'b0;
        drain(20);
        check("end_idle", 32'(Busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
